// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and reset constants for the synchronous FIFO controller.
package sync_fifo_pkg;

    localparam int PTR_RST = 0;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    function automatic int addr_w(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic int DEPTH_OF(input int a);
        return 1 << a;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer: registered incrementer with synchronous reset and count enable.
module fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    // Natural 2^W roll-over gives the modulo 2*DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= W'(PTR_RST);
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO sequencer: pointers, memory enables, status flags, read-valid strobe.
// Define SYNC_FIFO_CTRL_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic                rd_req,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic                mem_wr_en,
    output logic                mem_rd_en,
    output logic                wr_full,
    output logic                rd_empty,
    output logic                rd_valid,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty
`ifdef SYNC_FIFO_CTRL_ERR_EN
    ,
    output logic                overflow,
    output logic                underflow
`endif
);

    localparam int PTR_W = addr_w(ADDRSIZE);
    localparam int MSB   = PTR_W - 1;
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] ptr_q [2];
    logic [1:0]       ptr_inc;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_acc;
    logic             rd_acc;
    logic             rd_valid_reg;

    // Index 0 is the write pointer, index 1 the read pointer.
    assign ptr_inc = {rd_acc, wr_acc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr #(
                .W(PTR_W)
            ) u_ptr (
                .clk(clk),
                .rst(rst),
                .inc(ptr_inc[gi]),
                .ptr(ptr_q[gi])
            );
        end
    endgenerate

    assign wptr = ptr_q[0];
    assign rptr = ptr_q[1];

    assign wr_acc    = wr_req & ~wr_full;
    assign rd_acc    = rd_req & ~rd_empty;
    assign mem_wr_en = wr_acc;
    assign mem_rd_en = rd_acc;

    assign wr_addr = wptr[ADDRSIZE-1:0];
    assign rd_addr = rptr[ADDRSIZE-1:0];

    // Flags depend only on registered pointers, never on the requests.
    assign rd_empty     = (wptr == rptr);
    assign wr_full      = (wptr[MSB] != rptr[MSB]) &&
                          (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AFULL_LVL);
    assign almost_empty = (count <= AEMPTY_LVL);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_acc;
        end
    end

    assign rd_valid = rd_valid_reg;

`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_req && wr_full) begin
                overflow_reg <= 1'b1;
            end
            if (rd_req && rd_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl: vector table, corner sequences and random traffic vs a queue model.
module tb_sync_fifo_ctrl;
    import sync_fifo_pkg::*;

    localparam int AS    = 4;
    localparam int DEPTH = DEPTH_OF(AS);
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [AS-1:0] wr_addr;
    logic [AS-1:0] rd_addr;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic          wr_full;
    logic          rd_empty;
    logic          rd_valid;
    logic [AS:0]   count;
    logic          almost_full;
    logic          almost_empty;
`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo_ctrl #(
        .ADDRSIZE(AS),
        .AFULL_THRESH(AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_req(wr_req),
        .rd_req(rd_req),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en),
        .wr_full(wr_full),
        .rd_empty(rd_empty),
        .rd_valid(rd_valid),
        .count(count),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
`ifdef SYNC_FIFO_CTRL_ERR_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the dual-port memory the controller drives.
    logic [7:0] mem [DEPTH];
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;

    always @(posedge clk) begin
        if (mem_wr_en) mem[wr_addr] <= wr_data;
        if (mem_rd_en) rd_data <= mem[rd_addr];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q[$];
    logic [7:0] next_data = 8'h00;
    int         n_push = 0;
    int         n_pop  = 0;
    logic       last_wen;
    logic       last_ren;

    typedef struct {
        logic wr;
        logic rd;
        logic exp_wen;
        logic exp_ren;
        int   exp_count;
        logic exp_full;
        logic exp_empty;
        logic exp_af;
        logic exp_ae;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic wr, input logic rd, input logic wen,
                                input logic ren, input int cnt);
        vec_t v;
        v.wr = wr;
        v.rd = rd;
        v.exp_wen = wen;
        v.exp_ren = ren;
        v.exp_count = cnt;
        v.exp_full = (cnt == 16);
        v.exp_empty = (cnt == 0);
        v.exp_af = (cnt >= 14);
        v.exp_ae = (cnt <= 2);
        vecs.push_back(v);
    endfunction

    function automatic void model_reset();
        model_q.delete();
        n_push = 0;
        n_pop = 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_empty", rd_empty, 1);
        chk("rst_full", wr_full, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`endif
        $display("tx reset count=%0d empty=%0d", count, rd_empty);
    endtask

    // One clock of traffic: enables/addresses checked before the edge, state after it.
    task automatic step(input logic wr, input logic rd);
        logic       acc_w;
        logic       acc_r;
        logic [7:0] exp_val;
        exp_val = 8'h00;
        wr_req = wr;
        rd_req = rd;
        wr_data = next_data;
        #1;
        acc_w = wr && (model_q.size() != DEPTH);
        acc_r = rd && (model_q.size() != 0);
        last_wen = mem_wr_en;
        last_ren = mem_rd_en;
        chk("mem_wr_en", mem_wr_en, acc_w);
        chk("mem_rd_en", mem_rd_en, acc_r);
        chk("wr_addr", wr_addr, n_push % DEPTH);
        chk("rd_addr", rd_addr, n_pop % DEPTH);
        @(posedge clk);
        if (acc_r) begin
            exp_val = model_q.pop_front();
            n_pop++;
        end
        if (acc_w) begin
            model_q.push_back(next_data);
            next_data = next_data + 8'd1;
            n_push++;
        end
        @(negedge clk);
        chk("rd_valid", rd_valid, acc_r);
        if (acc_r) chk("rd_data", rd_data, exp_val);
        chk("count", count, model_q.size());
        chk("wr_full", wr_full, model_q.size() == DEPTH);
        chk("rd_empty", rd_empty, model_q.size() == 0);
        chk("almost_full", almost_full, model_q.size() >= AF);
        chk("almost_empty", almost_empty, model_q.size() <= AE);
        $display("tx wr=%0d rd=%0d wen=%0d ren=%0d count=%0d valid=%0d data=%02h",
                 wr, rd, last_wen, last_ren, count, rd_valid, rd_data);
    endtask

    initial begin
        int ovf_idx;
        int udf_idx;
        int p_wr;
        int p_rd;

        for (int i = 0; i < 16; i++) add(1, 0, 1, 0, i + 1);
        ovf_idx = vecs.size();
        add(1, 0, 0, 0, 16);
        add(1, 1, 0, 1, 15);
        add(1, 0, 1, 0, 16);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 1, 15 - i);
        udf_idx = vecs.size();
        add(0, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 2 + i);
        add(1, 1, 1, 1, 5);

        apply_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].rd);
            chk("tbl_wen", last_wen, vecs[i].exp_wen);
            chk("tbl_ren", last_ren, vecs[i].exp_ren);
            chk("tbl_count", count, vecs[i].exp_count);
            chk("tbl_full", wr_full, vecs[i].exp_full);
            chk("tbl_empty", rd_empty, vecs[i].exp_empty);
            chk("tbl_afull", almost_full, vecs[i].exp_af);
            chk("tbl_aempty", almost_empty, vecs[i].exp_ae);
            chk("tbl_valid", rd_valid, vecs[i].exp_ren);
`ifdef SYNC_FIFO_CTRL_ERR_EN
            chk("tbl_overflow", overflow, i >= ovf_idx);
            chk("tbl_underflow", underflow, i >= udf_idx);
`else
            if (i == ovf_idx || i == udf_idx) chk("tbl_reject_count", count, vecs[i].exp_count);
`endif
        end

        // Streamed pairs at count 5: addresses wrap several times, occupancy holds.
        for (int i = 0; i < 40; i++) begin
            step(1, 1);
            chk("stream_count", count, 5);
        end

        apply_reset();
        for (int phase = 0; phase < 4; phase++) begin
            p_wr = (phase % 2 == 0) ? 75 : 30;
            p_rd = (phase % 2 == 0) ? 35 : 70;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd);
            end
        end

        // Reset with an accepted pop in the same cycle.
        apply_reset();
        for (int i = 0; i < 7; i++) step(1, 0);
        chk("pre_rst_count", count, 7);
        rst = 1'b1;
        rd_req = 1'b1;
        wr_req = 1'b0;
        #1;
        chk("rst_cycle_rd_en", mem_rd_en, 1);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_count", count, 0);
        chk("midrst_empty", rd_empty, 1);
        chk("midrst_valid", rd_valid, 0);
        $display("tx midreset count=%0d empty=%0d valid=%0d", count, rd_empty, rd_valid);
        rst = 1'b0;
        rd_req = 1'b0;
        model_reset();
        step(1, 0);
        step(0, 1);
        step(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock sequencer for the team's dual-port FIFO memory (registered read, write gated by full, read gated by empty).
- Owns the write and read pointers and drives the memory's address and enable pins.
- Computes the full, empty, occupancy and almost-full/almost-empty status.
- Tracks the one-cycle read latency with a valid strobe.
- Sits between user push/pop logic and the memory instance; both memory clocks are tied to clk.

Parameters:
ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE.
AFULL_THRESH, 14, almost_full asserts when count >= AFULL_THRESH.
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
clk  input  1  single clock for the controller and both memory ports.
rst  input  1  synchronous, active-high reset.
wr_req  input  1  user push request.
rd_req  input  1  user pop request.
wr_addr  output  ADDRSIZE  memory write address.
rd_addr  output  ADDRSIZE  memory read address.
mem_wr_en  output  1  memory write enable.
mem_rd_en  output  1  memory read enable.
wr_full  output  1  FIFO full; also drives the memory's wr_full.
rd_empty  output  1  FIFO empty; also drives the memory's rd_empty.
rd_valid  output  1  memory rd_data is valid this cycle.
count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
almost_full  output  1  occupancy threshold flag.
almost_empty  output  1  occupancy threshold flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on port rst, clock port clk.
- Pointers: wptr and rptr are each ADDRSIZE+1 bits, binary. Address outputs are ptr[ADDRSIZE-1:0], driven combinationally from the registered pointers.
- Accept rules: wr_acc = wr_req & !wr_full; rd_acc = rd_req & !rd_empty.
  - mem_wr_en = wr_acc; mem_rd_en = rd_acc. The controller never drives an enable the memory would reject.
  - On a clk edge, wptr increments when wr_acc; rptr increments when rd_acc.
- Wrap-around: each pointer wraps modulo 2*DEPTH. The MSB toggles every DEPTH accepts.
- Status flags: combinational from the registered pointers only; no combinational path from wr_req/rd_req to any flag.
  - rd_empty = (wptr == rptr).
  - wr_full = (wptr[MSB] != rptr[MSB]) && (low bits equal).
  - count = wptr - rptr, in ADDRSIZE+1-bit arithmetic.
  - almost_full = count >= AFULL_THRESH; almost_empty = count <= AEMPTY_THRESH.
- Read latency:
  - rd_valid is registered: rd_valid <= rd_acc, so it is high exactly in the cycle after an accepted pop.
  - Memory rd_data must be sampled only when rd_valid = 1; it is high-Z otherwise.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected; next cycle count = DEPTH-1 and wr_full = 0.
  - When empty: push accepted, pop rejected; next cycle count = 1 and rd_empty = 0.
  - Otherwise both accepted and count is unchanged.
- Reset values: wptr = rptr = 0, rd_valid = 0. Hence rd_empty = 1, wr_full = 0, count = 0, almost_empty = 1, almost_full = 0, and both addresses are 0.
- Reset mid-operation: contents are abandoned and nothing is flushed. A pop accepted in the cycle rst is high does not advance rptr and yields rd_valid = 0 next cycle. mem_wr_en may still pulse in that cycle; the written data is discarded because wptr resets.
- Legal configurations: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH. Other values are out of range for this block.

Optional Feature:
Macro SYNC_FIFO_CTRL_ERR_EN.
- Defined: adds sticky outputs overflow and underflow, 1 bit each, reset to 0.
  - overflow sets when wr_req & wr_full on a clk edge.
  - underflow sets when rd_req & rd_empty on a clk edge.
  - Both clear only on rst.
- Undefined: neither port exists, no extra flops are built, and rejected requests are silently dropped.

Decomposition:
- Package sync_fifo_pkg holds:
  - function addr_w(ADDRSIZE) returning the pointer width ADDRSIZE+1;
  - localparam helper DEPTH_OF(a) = 1<<a;
  - typedef-free constant PTR_RST = 0.
- One sub-module, fifo_ptr: ADDRSIZE+1-bit registered incrementer with sync reset and an inc enable. Instantiated twice, for wptr and rptr.
- Flag logic stays in the top level.

Test Plan:
- Reset, then idle → rd_empty = 1, wr_full = 0, count = 0, almost_empty = 1, rd_valid = 0, wr_addr = rd_addr = 0.
- 16 pushes of 0x00..0x0F with ADDRSIZE = 4 → wr_full = 1 after the 16th edge, count = 16, almost_full from count 14. A 17th push gives mem_wr_en = 0 and the pointer unchanged; overflow = 1 when the macro is defined.
- Pop 16 → rd_valid one cycle after each accept, data 0x00..0x0F in order. rd_empty = 1 after the last; an extra pop gives mem_rd_en = 0, and underflow = 1 with the macro defined.
- Simultaneous push and pop at full, at empty and at count = 5 → counts 15, 1 and 5 respectively, per the accept rules.
- 40 push/pop pairs streamed → addresses wrap 15→0, pointer MSB toggles, count steady, data order preserved.
- rst asserted while count = 7 with rd_req = 1 → next cycle count = 0, rd_empty = 1, rd_valid = 0.
